// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : ID-stage hazard bundle between the core datapath (master)
//               and the hazard/forwarding/flush controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 3
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  // ID-stage instruction fields and pipeline events
  logic                  i_id_valid;
  logic [REG_ADDR_W-1:0] i_id_rs1;
  logic                  i_id_rs1_used;
  logic [REG_ADDR_W-1:0] i_id_rs2;
  logic                  i_id_rs2_used;
  logic [REG_ADDR_W-1:0] i_id_rd;
  logic                  i_id_reg_write;
  logic                  i_id_is_load;
  logic                  i_redirect;
  logic                  i_mem_busy;

  // Pipeline control back to the datapath
  logic                  o_stall;
  logic                  o_flush;
  logic                  o_bubble;
  logic                  o_freeze;
  logic [SEL_W-1:0]      o_fwd_sel_a;
  logic [SEL_W-1:0]      o_fwd_sel_b;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs1_used, i_id_rs2, i_id_rs2_used,
           i_id_rd, i_id_reg_write, i_id_is_load, i_redirect, i_mem_busy,
    input  o_stall, o_flush, o_bubble, o_freeze, o_fwd_sel_a, o_fwd_sel_b
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs1_used, i_id_rs2, i_id_rs2_used,
           i_id_rd, i_id_reg_write, i_id_is_load, i_redirect, i_mem_busy,
    output o_stall, o_flush, o_bubble, o_freeze, o_fwd_sel_a, o_fwd_sel_b
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard, forwarding and flush controller for the RV32I core.
//               Keeps a shadow scoreboard of the post-ID stages (entry 0 = EX)
//               to produce forward selects, load-use stalls, multi-cycle
//               front-end flushes and memory-busy freezes.
//               Optional macro HAZARD_PERF_CNT_EN adds saturating 32-bit
//               stall/flush/freeze event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FWD_DEPTH    = 3,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  wire logic             i_clk,
  input  wire logic             i_reset,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           o_stall_cnt,
  output logic [31:0]           o_flush_cnt,
  output logic [31:0]           o_freeze_cnt
`endif
);
  localparam int         SEL_W          = $clog2(FWD_DEPTH + 1);
  localparam logic [2:0] C_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [FWD_DEPTH-1:0]                 sb_valid_q, sb_valid_d;
  logic [FWD_DEPTH-1:0]                 sb_wr_q, sb_wr_d;
  logic [FWD_DEPTH-1:0]                 sb_load_q, sb_load_d;
  logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0] sb_rd_q, sb_rd_d;
  logic [2:0]                           flush_cnt_q, flush_cnt_d;
  logic                                 pend_q, pend_d;

  logic [SEL_W-1:0] sel_a, sel_b;
  logic             lu_a, lu_b;
  logic             freeze, redir_now, flush_act, load_use, stall, bubble;

  // Youngest matching producer per source; the loop runs oldest-first so the
  // lowest index is written last and wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (sb_valid_q[k] && sb_wr_q[k] && hz.i_id_rs1_used &&
          (hz.i_id_rs1 != '0) && (sb_rd_q[k] == hz.i_id_rs1)) begin
        sel_a = SEL_W'(k + 1);
        lu_a  = sb_load_q[k] && (k < LOAD_LATENCY);
      end
      if (sb_valid_q[k] && sb_wr_q[k] && hz.i_id_rs2_used &&
          (hz.i_id_rs2 != '0) && (sb_rd_q[k] == hz.i_id_rs2)) begin
        sel_b = SEL_W'(k + 1);
        lu_b  = sb_load_q[k] && (k < LOAD_LATENCY);
      end
    end
  end

  // Control decision: freeze beats flush, flush beats load-use stall.
  // Outputs are forced low while reset is held so they clear immediately.
  always_comb begin
    freeze    = hz.i_mem_busy;
    redir_now = hz.i_redirect | pend_q;
    flush_act = !freeze && (redir_now || (flush_cnt_q != 3'd0));
    load_use  = !freeze && (lu_a || lu_b);
    stall     = freeze || (load_use && !flush_act);
    bubble    = flush_act || load_use;

    hz.o_freeze    = freeze    & ~i_reset;
    hz.o_stall     = stall     & ~i_reset;
    hz.o_flush     = flush_act & ~i_reset;
    hz.o_bubble    = bubble    & ~i_reset;
    hz.o_fwd_sel_a = i_reset ? '0 : sel_a;
    hz.o_fwd_sel_b = i_reset ? '0 : sel_b;
  end

  // Next state: shift the scoreboard and run the flush counter unless frozen;
  // a redirect seen while frozen is parked until the first free cycle.
  always_comb begin
    sb_valid_d  = sb_valid_q;
    sb_wr_d     = sb_wr_q;
    sb_load_d   = sb_load_q;
    sb_rd_d     = sb_rd_q;
    flush_cnt_d = flush_cnt_q;
    pend_d      = pend_q;
    if (freeze) begin
      if (hz.i_redirect) begin
        pend_d = 1'b1;
      end
    end else begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        sb_valid_d[k] = sb_valid_q[k-1];
        sb_wr_d[k]    = sb_wr_q[k-1];
        sb_load_d[k]  = sb_load_q[k-1];
        sb_rd_d[k]    = sb_rd_q[k-1];
      end
      sb_valid_d[0] = hz.i_id_valid && !stall && !flush_act;
      sb_wr_d[0]    = hz.i_id_reg_write;
      sb_load_d[0]  = hz.i_id_is_load;
      sb_rd_d[0]    = hz.i_id_rd;
      pend_d        = 1'b0;
      if (redir_now) begin
        flush_cnt_d = C_FLUSH_RELOAD;
      end else if (flush_cnt_q != 3'd0) begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end
  end

  // State registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sb_valid_q  <= '0;
      sb_wr_q     <= '0;
      sb_load_q   <= '0;
      sb_rd_q     <= '0;
      flush_cnt_q <= 3'd0;
      pend_q      <= 1'b0;
    end else begin
      sb_valid_q  <= sb_valid_d;
      sb_wr_q     <= sb_wr_d;
      sb_load_q   <= sb_load_d;
      sb_rd_q     <= sb_rd_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_ev_q, flush_cnt_ev_d;
  logic [31:0] freeze_cnt_q, freeze_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_ev_d = flush_cnt_ev_q;
    freeze_cnt_d   = freeze_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush_act && (flush_cnt_ev_q != 32'hFFFF_FFFF)) begin
      flush_cnt_ev_d = flush_cnt_ev_q + 32'd1;
    end
    if (freeze && (freeze_cnt_q != 32'hFFFF_FFFF)) begin
      freeze_cnt_d = freeze_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q    <= '0;
      flush_cnt_ev_q <= '0;
      freeze_cnt_q   <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_ev_q <= flush_cnt_ev_d;
      freeze_cnt_q   <= freeze_cnt_d;
    end
  end

  assign o_stall_cnt  = stall_cnt_q;
  assign o_flush_cnt  = flush_cnt_ev_q;
  assign o_freeze_cnt = freeze_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed plus randomized bench for pipeline_hazard_ctrl with
//               an instruction-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
  localparam int RW = 5;
  localparam int FD = 3;
  localparam int LL = 1;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW), .FWD_DEPTH(FD)) hz_if ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
  int m_stall_cnt, m_flush_cnt, m_freeze_cnt;
`endif

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(RW), .FWD_DEPTH(FD), .LOAD_LATENCY(LL), .FLUSH_CYCLES(FC)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .hz      (hz_if)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_stall_cnt  (stall_cnt),
    .o_flush_cnt  (flush_cnt),
    .o_freeze_cnt (freeze_cnt)
`endif
  );

  // Reference model: history of instructions that left ID, youngest first,
  // plus a flush window measured in non-frozen cycles.
  typedef struct packed {
    logic          v;
    logic [RW-1:0] rd;
    logic          wr;
    logic          ld;
  } ent_t;

  ent_t pipe [$];
  int   nf;
  int   flush_until;
  bit   pend;
  logic e_stall, e_flush, e_bubble, e_freeze;
  logic [1:0] e_sa, e_sb;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < FD; i++) pipe.push_back('0);
    nf = 0;
    flush_until = 0;
    pend = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    m_stall_cnt = 0; m_flush_cnt = 0; m_freeze_cnt = 0;
`endif
  endfunction

  function automatic void scan(input logic [RW-1:0] rs, input logic used,
                               output logic [1:0] sel, output logic lu);
    sel = 2'd0;
    lu  = 1'b0;
    for (int i = 0; i < pipe.size(); i++) begin
      if (pipe[i].v && pipe[i].wr && used && rs != 0 && pipe[i].rd == rs) begin
        sel = 2'(i + 1);
        lu  = pipe[i].ld && (i < LL);
        break;
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [RW-1:0] rs1, input logic u1,
                       input logic [RW-1:0] rs2, input logic u2, input logic [RW-1:0] rd,
                       input logic wr, input logic ld, input logic redir, input logic busy);
    @(negedge clk);
    hz_if.i_id_valid     = v;
    hz_if.i_id_rs1       = rs1;
    hz_if.i_id_rs1_used  = u1;
    hz_if.i_id_rs2       = rs2;
    hz_if.i_id_rs2_used  = u2;
    hz_if.i_id_rd        = rd;
    hz_if.i_id_reg_write = wr;
    hz_if.i_id_is_load   = ld;
    hz_if.i_redirect     = redir;
    hz_if.i_mem_busy     = busy;
  endtask

  task automatic eval_cycle(input string tag);
    logic lua, lub, flushing;
    #1;
    scan(hz_if.i_id_rs1, hz_if.i_id_rs1_used, e_sa, lua);
    scan(hz_if.i_id_rs2, hz_if.i_id_rs2_used, e_sb, lub);
    if (hz_if.i_mem_busy) begin
      e_freeze = 1'b1; e_stall = 1'b1; e_flush = 1'b0; e_bubble = 1'b0;
    end else begin
      flushing = hz_if.i_redirect || pend || (nf < flush_until);
      e_freeze = 1'b0;
      e_flush  = flushing;
      e_stall  = (lua || lub) && !flushing;
      e_bubble = flushing || lua || lub;
    end
    chk({tag, ":freeze"}, hz_if.o_freeze, e_freeze);
    chk({tag, ":stall"},  hz_if.o_stall,  e_stall);
    chk({tag, ":flush"},  hz_if.o_flush,  e_flush);
    chk({tag, ":bubble"}, hz_if.o_bubble, e_bubble);
    if (!e_stall) begin
      chk({tag, ":sel_a"}, hz_if.o_fwd_sel_a, e_sa);
      chk({tag, ":sel_b"}, hz_if.o_fwd_sel_b, e_sb);
    end
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ":stall_cnt"},  stall_cnt,  m_stall_cnt);
    chk({tag, ":flush_cnt"},  flush_cnt,  m_flush_cnt);
    chk({tag, ":freeze_cnt"}, freeze_cnt, m_freeze_cnt);
`endif
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
    m_stall_cnt  += int'(e_stall);
    m_flush_cnt  += int'(e_flush);
    m_freeze_cnt += int'(e_freeze);
`endif
    if (hz_if.i_mem_busy) begin
      if (hz_if.i_redirect) pend = 1'b1;
    end else begin
      if (hz_if.i_redirect || pend) flush_until = nf + FC;
      pend = 1'b0;
      e.v  = hz_if.i_id_valid && !e_stall && !e_flush;
      e.rd = hz_if.i_id_rd;
      e.wr = hz_if.i_id_reg_write;
      e.ld = hz_if.i_id_is_load;
      pipe.push_front(e);
      void'(pipe.pop_back());
      nf++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":stall"},  hz_if.o_stall,  1'b0);
    chk({tag, ":flush"},  hz_if.o_flush,  1'b0);
    chk({tag, ":bubble"}, hz_if.o_bubble, 1'b0);
    chk({tag, ":freeze"}, hz_if.o_freeze, 1'b0);
    chk({tag, ":sel_a"},  hz_if.o_fwd_sel_a, 2'd0);
    chk({tag, ":sel_b"},  hz_if.o_fwd_sel_b, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ":stall_cnt"},  stall_cnt,  32'd0);
    chk({tag, ":flush_cnt"},  flush_cnt,  32'd0);
    chk({tag, ":freeze_cnt"}, freeze_cnt, 32'd0);
`endif
  endtask

  initial begin
    model_reset();
    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load-use: lw x5 then add x6,x5,x1
    drive(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0); eval_cycle("lw_x5"); tick();
    drive(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0); eval_cycle("lu_stall");
    chk("lu_stall:stall_lit", hz_if.o_stall, 1'b1);
    chk("lu_stall:bubble_lit", hz_if.o_bubble, 1'b1);
    tick();
    drive(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0); eval_cycle("lu_fwd");
    chk("lu_fwd:stall_lit", hz_if.o_stall, 1'b0);
    chk("lu_fwd:sel_a_lit", hz_if.o_fwd_sel_a, 2'd2);
    tick();

    // ALU back-to-back forwarding on x3
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0); eval_cycle("add_x3"); tick();
    drive(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0, 0); eval_cycle("sub_x3");
    chk("sub_x3:sel_a_lit", hz_if.o_fwd_sel_a, 2'd1);
    chk("sub_x3:sel_b_lit", hz_if.o_fwd_sel_b, 2'd1);
    tick();
    drive(1, 5'd3, 1, 5'd0, 1, 5'd5, 1, 0, 0, 0); eval_cycle("or_x3");
    chk("or_x3:sel_a_lit", hz_if.o_fwd_sel_a, 2'd2);
    tick();

    // x0 never forwards, even from a load
    drive(1, 5'd1, 1, 5'd1, 1, 5'd0, 1, 0, 0, 0); eval_cycle("wr_x0"); tick();
    drive(1, 5'd1, 1, 5'd1, 1, 5'd0, 1, 1, 0, 0); eval_cycle("ld_x0"); tick();
    drive(1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0); eval_cycle("use_x0");
    chk("use_x0:stall_lit", hz_if.o_stall, 1'b0);
    chk("use_x0:sel_a_lit", hz_if.o_fwd_sel_a, 2'd0);
    chk("use_x0:sel_b_lit", hz_if.o_fwd_sel_b, 2'd0);
    tick();

    // Redirect over a coincident load-use: two flush cycles, no stall
    drive(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0); eval_cycle("lw_x7"); tick();
    drive(1, 5'd7, 1, 5'd0, 0, 5'd9, 1, 0, 1, 0); eval_cycle("redir0");
    chk("redir0:flush_lit", hz_if.o_flush, 1'b1);
    chk("redir0:stall_lit", hz_if.o_stall, 1'b0);
    tick();
    drive(1, 5'd7, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0); eval_cycle("redir1");
    chk("redir1:flush_lit", hz_if.o_flush, 1'b1);
    tick();
    drive(1, 5'd7, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0); eval_cycle("redir2");
    chk("redir2:flush_lit", hz_if.o_flush, 1'b0);
    tick();

    // Freeze for 3 cycles, redirect in the second; flush when busy drops
    drive(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0); eval_cycle("add_x9"); tick();
    for (int c = 0; c < 3; c++) begin
      drive(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, (c == 1), 1); eval_cycle("frz");
      chk("frz:freeze_lit", hz_if.o_freeze, 1'b1);
      chk("frz:flush_lit", hz_if.o_flush, 1'b0);
      tick();
    end
    drive(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 0, 0); eval_cycle("unfrz");
    chk("unfrz:flush_lit", hz_if.o_flush, 1'b1);
    chk("unfrz:sel_a_lit", hz_if.o_fwd_sel_a, 2'd1);
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0); eval_cycle("idle"); tick();

    // Asynchronous reset in the middle of a load-use stall
    drive(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0); eval_cycle("lw_x5b"); tick();
    drive(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0); eval_cycle("lu_b");
    chk("lu_b:stall_lit", hz_if.o_stall, 1'b1);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic on a small register set to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom % 8) != 0,
            RW'($urandom_range(0, 4)), ($urandom % 4) != 0,
            RW'($urandom_range(0, 4)), ($urandom % 2) != 0,
            RW'($urandom_range(0, 4)), ($urandom % 4) != 0,
            ($urandom % 3) == 0, ($urandom % 10) == 0, ($urandom % 8) == 0);
      eval_cycle("rnd");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
